// File: rtl/gsram_grid_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | gsram_pkg: shared state encoding, source selects, default sizes. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package gsram_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic SRC_M2  = 1'b0;
  localparam logic SRC_LUT = 1'b1;

  localparam int DEF_ROWS   = 10;
  localparam int DEF_COLS   = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ROW_W  = 4;
  localparam int DEF_COL_W  = 4;

endpackage

`default_nettype wire

// File: rtl/gsram_grid_ctrl_if.sv
// +------------------------------------------------------------------+
// | gsram_grid_ctrl_if: request/response bus (req_acc with            |
// | GSRAM_GRID_ACC_EN). Rev 1.0                                       |
// +------------------------------------------------------------------+
`default_nettype none

interface gsram_grid_ctrl_if #(
  parameter int ROW_W  = gsram_pkg::DEF_ROW_W,
  parameter int COL_W  = gsram_pkg::DEF_COL_W,
  parameter int DATA_W = gsram_pkg::DEF_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic              src_sel;
  logic [DATA_W-1:0] m2result;
  logic [DATA_W-1:0] lutdata;
`ifdef GSRAM_GRID_ACC_EN
  logic              req_acc;
`endif
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              addr_err;

  modport master (
    output req_valid, req_we, req_row, req_col, src_sel, m2result, lutdata,
`ifdef GSRAM_GRID_ACC_EN
    output req_acc,
`endif
    input  req_ready, rdata, rdata_valid, addr_err
  );

  modport slave (
    input  req_valid, req_we, req_row, req_col, src_sel, m2result, lutdata,
`ifdef GSRAM_GRID_ACC_EN
    input  req_acc,
`endif
    output req_ready, rdata, rdata_valid, addr_err
  );

endinterface

`default_nettype wire

// File: rtl/gsram_grid_ctrl_clear_seq.sv
// +------------------------------------------------------------------+
// | gsram_clear_seq: row-major sweep counter for the array clear.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module gsram_clear_seq
  import gsram_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int ROW_W = DEF_ROW_W,
  parameter int COL_W = DEF_COL_W
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  output logic      [ROW_W-1:0] row,
  output logic      [COL_W-1:0] col,
  output logic                  active,
  output logic                  done
);

  localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(COLS - 1);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_last;

  assign w_last = (r_row == C_LAST_ROW) && (r_col == C_LAST_COL);

  // Row/col counters step together as one linear index i = row*COLS + col.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (en) begin
      if (r_col == C_LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == C_LAST_ROW) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign row    = r_row;
  assign col    = r_col;
  assign active = en;
  assign done   = en && w_last;

endmodule

`default_nettype wire

// File: rtl/gsram_grid_ctrl.sv
// +------------------------------------------------------------------+
// | gsram_grid_ctrl: row/col scratchpad with clear sweep; optional    |
// | accumulate-write via GSRAM_GRID_ACC_EN. Rev 1.0                   |
// +------------------------------------------------------------------+
`default_nettype none

module gsram_grid_ctrl
  import gsram_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int COL_W  = DEF_COL_W
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  gsram_grid_ctrl_if.slave bus,
  input  wire logic        clr_start,
  output logic             busy,
  output logic             clr_done
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] mem [ROWS][COLS];

  logic              w_accept;
  logic              w_in_range;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_cell;
  logic [DATA_W-1:0] w_store;
  logic              w_do_write;

  logic [ROW_W-1:0]  w_clr_row;
  logic [COL_W-1:0]  w_clr_col;
  logic              w_clr_active;
  logic              w_clr_done;

  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_addr_err;

  gsram_clear_seq #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_clear_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (r_state == ST_CLEAR),
    .row    (w_clr_row),
    .col    (w_clr_col),
    .active (w_clr_active),
    .done   (w_clr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_CLEAR;
    else        r_state <= w_state_nxt;
  end

  // clr_start is only looked at in IDLE, so a running sweep never restarts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clr_start)  w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_clr_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  assign busy          = (r_state == ST_CLEAR);
  assign clr_done      = w_clr_done;
  assign bus.req_ready = !busy;

  assign w_accept   = bus.req_valid && bus.req_ready;
  assign w_in_range = (32'(bus.req_row) < ROWS) && (32'(bus.req_col) < COLS);
  assign w_wdata    = (bus.src_sel == SRC_LUT) ? bus.lutdata : bus.m2result;
  assign w_cell     = w_in_range ? mem[bus.req_row][bus.req_col] : '0;

`ifdef GSRAM_GRID_ACC_EN
  assign w_store = bus.req_acc ? (w_cell + w_wdata) : w_wdata;
`else
  assign w_store = w_wdata;
`endif

  assign w_do_write = w_accept && bus.req_we && w_in_range;

  // Array has no reset; the sweep and request path never overlap in time.
  always_ff @(posedge clk) begin
    if (w_clr_active) begin
      mem[w_clr_row][w_clr_col] <= '0;
    end else if (w_do_write) begin
      mem[bus.req_row][bus.req_col] <= w_store;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_rdata_valid <= w_accept;
      r_addr_err    <= w_accept && !w_in_range;
      if (w_accept) r_rdata <= w_cell;
    end
  end

  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.addr_err    = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_gsram_grid_ctrl.sv
// +------------------------------------------------------------------+
// | tb_gsram_grid_ctrl: scoreboard bench for gsram_grid_ctrl.         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_gsram_grid_ctrl;
  import gsram_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clr_start = 1'b0;
  logic busy;
  logic clr_done;

  gsram_grid_ctrl_if #(.ROW_W(4), .COL_W(4), .DATA_W(16)) bus ();

  gsram_grid_ctrl #(
    .ROWS(10), .COLS(10), .DATA_W(16), .ROW_W(4), .COL_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_done  (clr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model [10][10];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Presents one request for exactly one clock; caller guarantees req_ready.
  task automatic req(input logic we, input int row, input int col, input logic sel,
                     input logic [15:0] wd, input logic acc,
                     input logic [15:0] exp_data, input logic exp_err);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_row   = 4'(row);
    bus.req_col   = 4'(col);
    bus.src_sel   = sel;
    bus.m2result  = (sel == SRC_M2)  ? wd : 16'hDEAD;
    bus.lutdata   = (sel == SRC_LUT) ? wd : 16'hDEAD;
`ifdef GSRAM_GRID_ACC_EN
    bus.req_acc   = acc;
`endif
    e.data = exp_data;
    e.err  = exp_err;
    exp_q.push_back(e);
    if (we && row < 10 && col < 10)
      model[row][col] = acc ? model[row][col] + wd : wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic rd(input int row, input int col);
    req(1'b0, row, col, SRC_M2, 16'h0000, 1'b0, model[row][col], 1'b0);
  endtask

  task automatic readback_all();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        rd(r, c);
  endtask

  // Counts busy cycles and clr_done pulses after a reset release, bounded.
  task automatic measure_sweep(input string tag);
    int bcnt = 0;
    int dcnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (clr_done) dcnt++;
      if (busy) bcnt++;
      else break;
    end
    check({tag, "_busy_cycles"}, bcnt, 100);
    check({tag, "_clr_done_pulses"}, dcnt, 1);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        model[r][c] = 16'h0000;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.src_sel   = 1'b0;
    bus.m2result  = '0;
    bus.lutdata   = '0;
`ifdef GSRAM_GRID_ACC_EN
    bus.req_acc   = 1'b0;
`endif

    fork
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
          if (bus.rdata_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_rdata_valid: got rdata=0x%0h want no response", bus.rdata);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              check("rdata", bus.rdata, e.data);
              check("addr_err", bus.addr_err, e.err);
            end
          end else if (bus.addr_err !== 1'b0) begin
            check("addr_err_without_valid", bus.addr_err, 0);
          end
        end
      end
    join_none

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_rdata_valid", bus.rdata_valid, 0);
    check("rst_addr_err", bus.addr_err, 0);
    check("rst_clr_done", clr_done, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    measure_sweep("boot");

    rd(0, 0);
    rd(9, 9);

    req(1'b1, 3, 7, SRC_M2,  16'h1234, 1'b0, 16'h0000, 1'b0);
    req(1'b0, 3, 7, SRC_M2,  16'h0000, 1'b0, 16'h1234, 1'b0);
    req(1'b1, 3, 7, SRC_LUT, 16'hBEEF, 1'b0, 16'h1234, 1'b0);
    req(1'b0, 3, 7, SRC_M2,  16'h0000, 1'b0, 16'hBEEF, 1'b0);

    req(1'b1, 10, 0, SRC_M2, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    req(1'b1, 0, 10, SRC_LUT, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    req(1'b0, 15, 15, SRC_M2, 16'h0000, 1'b0, 16'h0000, 1'b1);
    req(1'b1, 9, 0, SRC_M2,  16'h5A5A, 1'b0, 16'h0000, 1'b0);
    req(1'b1, 0, 9, SRC_LUT, 16'hA5A5, 1'b0, 16'h0000, 1'b0);
    readback_all();

`ifdef GSRAM_GRID_ACC_EN
    req(1'b1, 2, 2, SRC_M2,  16'hFFF0, 1'b0, 16'h0000, 1'b0);
    req(1'b1, 2, 2, SRC_LUT, 16'h0020, 1'b1, 16'hFFF0, 1'b0);
    req(1'b1, 2, 2, SRC_M2,  16'h0020, 1'b1, 16'h0010, 1'b0);
    req(1'b0, 2, 2, SRC_M2,  16'h0000, 1'b0, 16'h0030, 1'b0);
`endif

    // Write coincident with clr_start completes, then the sweep begins.
    clr_start = 1'b1;
    req(1'b1, 5, 5, SRC_M2, 16'h7777, 1'b0, 16'h0000, 1'b0);
    clr_start = 1'b0;
    #1;
    check("clear_entered_busy", busy, 1);
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midclear_rst_busy", busy, 1);
    #2 rst_n = 1'b1;
    measure_sweep("restart");
    readback_all();

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/gsram_grid_ctrl.md
Name: gsram_grid_ctrl

Overview:
- Parametrised successor of the fixed 10x10x16 gSRAM: a row/col-addressed scratchpad holding matrix tiles between the M2 datapath and the LUT unit.
- Adds a valid/ready request port, range checking, a read-valid strobe, and a hardware clear sequencer.
- The clear sequencer also runs automatically out of reset, replacing the simulation-only initial block.

Parameters:
- ROWS, 10, number of rows.
- COLS, 10, number of columns.
- DATA_W, 16, element width in bits.
- ROW_W, 4, row address width; must satisfy 2**ROW_W >= ROWS.
- COL_W, 4, column address width; must satisfy 2**COL_W >= COLS.

Ports:
- clk  in  1  sole clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; equals !busy.
- req_we  in  1  1 = write, 0 = read.
- req_row  in  ROW_W  row address.
- req_col  in  COL_W  column address.
- src_sel  in  1  write-data select: 0 = m2result, 1 = lutdata.
- m2result  in  DATA_W  write source 0.
- lutdata  in  DATA_W  write source 1.
- rdata  out  DATA_W  registered read data.
- rdata_valid  out  1  one-cycle strobe, rdata is valid.
- addr_err  out  1  one-cycle strobe, accepted request was out of range.
- clr_start  in  1  start a full-array clear.
- busy  out  1  clear in progress.
- clr_done  out  1  one-cycle strobe on the final clear write.

Behaviour:
- Reset (async assert): rdata=0, rdata_valid=0, addr_err=0, clr_done=0, clear index=0, state=CLEAR, busy=1.
- Memory contents are not reset directly; they are zeroed by the post-reset sweep.
- States:
  - IDLE: serves requests.
  - CLEAR: writes 0 to linear index i (row = i/COLS, col = i%COLS, row-major), one cell per cycle, i = 0..ROWS*COLS-1.
  - After the write at i = ROWS*COLS-1: clr_done pulses that cycle, next state is IDLE, busy drops, index returns to 0.
- IDLE -> CLEAR on clr_start=1. clr_start in CLEAR is ignored; the sweep does not restart.
- Reset asserted mid-clear restarts the sweep from index 0.
- A request is accepted when req_valid && req_ready. Requests presented during CLEAR are not accepted and cause no side effects.
- The first request is accepted ROWS*COLS cycles after reset deassertion.
- Write data = src_sel ? lutdata : m2result, sampled at the accepting edge.
- Accepted write: cell updated at that edge. Cell visible to a read accepted on the next cycle.
- Every accepted in-range request, read or write, returns the cell's pre-write contents on rdata on the following cycle, with rdata_valid=1 (read-before-write, matching gSRAM).
- rdata holds its value when rdata_valid=0.
- Out of range (req_row >= ROWS or req_col >= COLS):
  - write suppressed, rdata <= 0, rdata_valid=1;
  - addr_err=1 in the same cycle as rdata_valid.
- clr_start coincident with an accepted request in IDLE: the request completes normally; CLEAR begins the next cycle.
- Back-to-back requests are accepted every cycle with no bubbles.

Optional Feature:
- Macro: GSRAM_GRID_ACC_EN.
- Defined:
  - adds input req_acc (1 bit).
  - An accepted in-range write with req_acc=1 stores mem[row][col] + wdata, truncated modulo 2**DATA_W, in a single cycle.
  - rdata returns the pre-accumulate value.
  - Back-to-back accumulates to the same cell chain correctly.
- Not defined: req_acc port absent; all writes overwrite.

Decomposition:
- Package gsram_pkg:
  - state enum {ST_IDLE, ST_CLEAR};
  - SRC_M2 = 1'b0, SRC_LUT = 1'b1;
  - default ROWS/COLS/DATA_W constants.
- Sub-module gsram_clear_seq: linear index counter, row/col split, clr_done generation. Outputs clear row, col, active, done.
- Top level holds the array, request path and output registers.

Test Plan:
- Release rst_n -> busy=1 for exactly 100 cycles, clr_done pulses once, then req_ready=1; reads of (0,0) and (9,9) return 0.
- Write (3,7) m2result=0x1234 src_sel=0, then read (3,7) next cycle -> rdata=0x1234 with rdata_valid one cycle after the read.
- Write (3,7) lutdata=0xBEEF src_sel=1 over 0x1234 -> same-request rdata=0x1234; following read -> 0xBEEF.
- Request (10,0) write 0xFFFF -> addr_err=1, rdata=0, rdata_valid=1; array unchanged (full readback).
- clr_start with data present, then rst_n pulse at clear cycle 40 -> sweep restarts; req_ready stays 0 for 100 more cycles; all cells read 0.
- With GSRAM_GRID_ACC_EN: cell (2,2)=0xFFF0, accumulate 0x0020 twice back-to-back -> cell holds 0x0030 (wrapped); rdata sequence 0xFFF0, 0x0010.
